// File: rtl/avmm_if.sv
// avmm_if: Avalon-MM bus bundle between a burst master and a slave.
// The master drives the request side; the slave drives wait/read-return.
interface avmm_if #(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int LW = 3
);
  logic [AW-1:0]   address;
  logic [LW-1:0]   burstcount;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            waitrequest;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avmm_burst_master.sv
// avmm_burst_master: turns single client commands into complete Avalon-MM
// read or write bursts. Address and burstcount are latched at command accept
// and held for the whole burst; every beat honours waitrequest.
// Optional feature: define AVMM_MASTER_TIMEOUT_EN to build a watchdog that
// aborts a stalled burst after TIMEOUT cycles (TIMEOUT >= 2) with error=1.
module avmm_burst_master #(
  parameter int  AW        = 16,
  parameter int  DW        = 64,
  parameter int  MAX_BURST = 4,
  parameter int  TIMEOUT   = 256,
  localparam int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            done,
  output logic            error,
  avmm_if.master          bus
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, FIN} state_t;

  // Clears the byte-offset bits so bursts always start on a word boundary.
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(DW / 8 - 1);
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_BURST);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          beat_last;
  logic          timeout_hit;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0) return LW'(1);
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  assign beat_last      = (cnt_q == len_q - LW'(1));
  assign cmd_ready      = (state_q == IDLE);
  assign done           = (state_q == FIN);
  assign bus.address    = addr_q;
  assign bus.burstcount = len_q;
  assign bus.writedata  = wr_data;
  assign bus.byteenable = wr_be;

  // Next-state and bus-request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_ready  = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr & ADDR_MASK;
          len_d   = clamp_len(cmd_len);
          cnt_d   = '0;
          state_d = cmd_write ? WR : RD_REQ;
        end
      end
      WR: begin
        // The client may pause mid-burst; address/burstcount stay held.
        bus.write = wr_valid;
        if (wr_valid && !bus.waitrequest) begin
          wr_ready = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (beat_last) state_d = FIN;
        end
      end
      RD_REQ: begin
        bus.read = 1'b1;
        if (!bus.waitrequest) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.readdatavalid) begin
          cnt_d = cnt_q + 1'b1;
          if (beat_last) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = FIN;
  end

  // State, latched command and read-valid registers.
  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rd_valid <= (state_q == RD_DATA) && bus.readdatavalid;
    end
  end

  // Read-data capture, qualified by the same beat that raises rd_valid.
  always_ff @(posedge clock) begin
    // NOTE: pure datapath register; rd_valid qualifies it, so no reset.
    if (state_q == RD_DATA && bus.readdatavalid) rd_data <= bus.readdata;
  end

`ifdef AVMM_MASTER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q;
  logic           err_q;
  logic           busy;
  logic           progress;

  assign busy     = (state_q == WR) || (state_q == RD_REQ) || (state_q == RD_DATA);
  assign progress = ((state_q == WR) && wr_valid && !bus.waitrequest) ||
                    ((state_q == RD_REQ) && !bus.waitrequest) ||
                    ((state_q == RD_DATA) && bus.readdatavalid);
  // wd_q holds the number of cycles since the last progress cycle, so the
  // abort lands in FIN exactly TIMEOUT cycles after that progress cycle.
  assign timeout_hit = busy && !progress && (wd_q == WDW'(TIMEOUT - 1));
  assign error       = (state_q == FIN) && err_q;

  // Watchdog counter and abort flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy || progress) wd_q <= WDW'(1);
      else                   wd_q <= wd_q + 1'b1;
      if (timeout_hit)          err_q <= 1'b1;
      else if (state_q == FIN)  err_q <= 1'b0;
    end
  end
`else
  localparam bit unused_timeout = (TIMEOUT > 0);
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

endmodule

// File: doc/avmm_burst_master.md
# avmm_burst_master

Avalon-MM burst initiator that turns single commands from a local client (CPU bridge, DMA sequencer) into complete read or write bursts on an `avmm_if` bus. It is the master end for the team's Avalon-MM slaves:
- it holds address and burstcount for the whole burst;
- it honours `waitrequest` on every beat;
- it collects `readdatavalid` beats.

It sits between client logic and the fabric or slave, in the `clock` domain.

## Interface
- `AW`, 16, byte address width.
- `DW`, 64, data width in bits; a multiple of 8.
- `MAX_BURST`, 4, maximum beats per burst; a power of 2, at least 1.
- `TIMEOUT`, 256, watchdog cycles. Used only with `AVMM_MASTER_TIMEOUT_EN`.
- Width rule: LW = $clog2(MAX_BURST)+1.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 selects a write burst, 0 selects a read burst.
- `cmd_addr`  in  AW  byte start address.
- `cmd_len`  in  LW  beats requested.
- `wr_valid`  in  1  write beat available.
- `wr_ready`  out  1  write beat consumed this cycle.
- `wr_data`  in  DW  write data.
- `wr_be`  in  DW/8  byte enables.
- `rd_valid`  out  1  read beat valid. Single cycle; there is no backpressure.
- `rd_data`  out  DW  read data.
- `done`  out  1  one-cycle pulse when a burst completes or aborts.
- `error`  out  1  one-cycle pulse, coincident with `done`, on abort.
- `bus`  `avmm_if.master`  —  Avalon-MM signals: address, burstcount, read, write, writedata, byteenable, readdata, readdatavalid, waitrequest.

## Operation
Command capture:
- `cmd_ready` = (state == IDLE).
- On accept, latch:
  - address = `cmd_addr` with the low $clog2(DW/8) bits forced to 0;
  - len = `cmd_len` clamped to [1, MAX_BURST]. 0 becomes 1; more than MAX_BURST becomes MAX_BURST.
- Clear the beat counter `cnt`.

States:
- IDLE: wait for a command. Go to WR if `cmd_write`, else to RD_REQ.
- WR:
  - `bus.write` = `wr_valid`; `writedata` and `byteenable` pass through from the write port.
  - A beat completes when `bus.write && !bus.waitrequest`. `wr_ready` asserts in that same cycle and `cnt` increments.
  - When `wr_valid` is low, `write` drops. This is legal mid-burst; `address` and `burstcount` stay held.
  - After the len-th beat, go to FIN.
- RD_REQ:
  - `bus.read` = 1 with the latched address and burstcount.
  - When `!waitrequest`, go to RD_DATA. `read` deasserts in the next cycle.
- RD_DATA:
  - Each `readdatavalid` drives `rd_valid` and `rd_data`, and increments `cnt`.
  - After the len-th beat, go to FIN.
  - `readdatavalid` in any other state is ignored.
- FIN: pulse `done` for one cycle, then return to IDLE.

Bus outputs:
- `address` and `burstcount` are registered, and are stable from entry to WR/RD_REQ until exit.
- Outside WR/RD_REQ, `read` and `write` are 0.

Reset values:
- state is IDLE; `cnt` and the latched address/len are 0.
- `bus.read`, `bus.write`, `rd_valid`, `done`, `error`, `wr_ready` are 0.
- `cmd_ready` is 1 from the first cycle after reset deasserts.
- Reset mid-burst abandons the burst immediately, with no `done` pulse.

## Timing
- Command accept to first bus request: 1 cycle. `read` or `write` is high in the cycle after the handshake.
- Write throughput: 1 beat per cycle when `wr_valid` = 1 and `waitrequest` = 0.
- Read: `rd_valid` is registered, 1 cycle after the `readdatavalid` beat. `rd_data` is captured from `readdata` at the same edge.
- Last beat to `done`: 1 cycle. `done` to `cmd_ready`: 1 cycle.
- Back-to-back commands therefore cost 2 idle bus cycles.

## Configuration
`AVMM_MASTER_TIMEOUT_EN`:
- Defined:
  - A watchdog counts consecutive cycles in WR/RD_REQ/RD_DATA with no completed beat or request accept.
  - At `TIMEOUT` it forces FIN with `error` = 1.
  - `rd_valid` is not asserted for the missing beats.
- Undefined:
  - No watchdog is built; the block waits indefinitely.
  - `error` is constant 0.

## Test plan
- Single write:
  - Stimulus: `cmd_addr`=0x0008, len=1, `wr_data`=0xA5A5A5A5A5A5A5A5, `wr_be`=0xFF, slave `waitrequest` 2 cycles.
  - Required: `write` held for 3 cycles at address 0x0008, burstcount 1; one `wr_ready` pulse; `done` 1 cycle after the accepted beat.
- Burst read:
  - Stimulus: addr 0x0000, len=4; slave returns 0x1111111111111111, 0x2222222222222222, 0x3333333333333333, 0x4444444444444444 with a 1-cycle gap between the second and third.
  - Required: four `rd_valid` pulses in that order; `read` high for exactly 1 accepted cycle; `done` follows the 4th beat.
- Write burst throttling:
  - Stimulus: len=4, `wr_valid` low for 2 cycles after beat 2.
  - Required: `write` drops for those cycles; address/burstcount unchanged; 4 `wr_ready` pulses total; exactly one `done`.
- Length edges:
  - Stimulus: `cmd_len`=0 → burstcount 1; `cmd_len`=7 with MAX_BURST=4 → burstcount 4.
  - Required: unaligned `cmd_addr`=0x000D drives address 0x0008.
- Reset mid-burst:
  - Stimulus: assert `reset` after 2 of 4 read beats.
  - Required: next cycle `read`=0 and `rd_valid`=0, no `done`; `cmd_ready`=1 after release; a fresh read completes normally.
- Timeout (macro defined, `TIMEOUT`=16):
  - Stimulus: slave never returns `readdatavalid`.
  - Required: `done` and `error` pulse together 16 cycles after the request accept; the block is back in IDLE.
  - Undefined build: the block stays in RD_DATA and `error` never asserts.
